// File: rtl/tx_handshake_arbiter.sv
// Four-requester round-robin arbiter that forwards the winner's data word to a
// transmit-side handshake block (offer/busy cycle) with an optional watchdog.
module tx_handshake_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] req_data,
  output logic [3:0]      gnt,
  output logic [3:0]      done,
  output logic            data_avail,
  output logic [DW-1:0]   transmit_data,
  input  logic            t_rdy,
  output logic            timeout_err,
  output logic            busy
);

  localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_BUSY} state_e;

  state_e          state, state_nxt;
  logic [1:0]      last_gnt, last_gnt_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [3:0]      gnt_nxt, done_nxt;
  logic            data_avail_nxt, timeout_err_nxt, busy_nxt;
  logic [DW-1:0]   transmit_data_nxt;
  logic [1:0]      win;
  logic            found;
  logic            timeout_hit;

  // Round-robin search starts one past the previous winner and wraps.
  always_comb begin
    win   = last_gnt + 2'd1;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && req[last_gnt + 2'(i)]) begin
        win   = last_gnt + 2'(i);
        found = 1'b1;
      end
    end
  end

  assign cnt_inc     = (cnt == TMAX) ? cnt : cnt + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TMAX);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_nxt         = state;
    last_gnt_nxt      = last_gnt;
    cnt_nxt           = cnt;
    gnt_nxt           = gnt;
    done_nxt          = '0;
    data_avail_nxt    = data_avail;
    transmit_data_nxt = transmit_data;
    timeout_err_nxt   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (|req) begin
          state_nxt         = S_OFFER;
          last_gnt_nxt      = win;
          cnt_nxt           = '0;
          gnt_nxt           = '0;
          gnt_nxt[win]      = 1'b1;
          data_avail_nxt    = 1'b1;
          transmit_data_nxt = req_data[int'(win)*DW +: DW];
        end
      end
      S_OFFER: begin
        cnt_nxt = cnt_inc;
        if (timeout_hit) begin
          state_nxt         = S_IDLE;
          gnt_nxt           = '0;
          data_avail_nxt    = 1'b0;
          transmit_data_nxt = '0;
          timeout_err_nxt   = 1'b1;
        end else if (t_rdy) begin
          state_nxt      = S_BUSY;
          data_avail_nxt = 1'b0;
        end
      end
      S_BUSY: begin
        cnt_nxt = cnt_inc;
        // Completion wins over a watchdog expiry landing on the same edge.
        if (!t_rdy) begin
          state_nxt         = S_IDLE;
          done_nxt          = gnt;
          gnt_nxt           = '0;
          transmit_data_nxt = '0;
        end else if (timeout_hit) begin
          state_nxt         = S_IDLE;
          gnt_nxt           = '0;
          data_avail_nxt    = 1'b0;
          transmit_data_nxt = '0;
          timeout_err_nxt   = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      last_gnt      <= 2'd3;
      cnt           <= '0;
      gnt           <= '0;
      done          <= '0;
      data_avail    <= 1'b0;
      transmit_data <= '0;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_gnt      <= last_gnt_nxt;
      cnt           <= cnt_nxt;
      gnt           <= gnt_nxt;
      done          <= done_nxt;
      data_avail    <= data_avail_nxt;
      transmit_data <= transmit_data_nxt;
      timeout_err   <= timeout_err_nxt;
      busy          <= busy_nxt;
    end
  end

endmodule
